// File: rtl/memoria_instrucao_pkg.sv
// Processor-wide constants shared by the fetch path and the instruction memory.
package memoria_instrucao_pkg;

  localparam int unsigned LARGURA_INSTR     = 32;
  localparam int unsigned PROFUNDIDADE_IMEM = 256;

  localparam logic [LARGURA_INSTR-1:0] INSTR_NOP = 32'h0000_0000;

endpackage : memoria_instrucao_pkg

// File: rtl/memoria_instrucao.sv
// Word-addressed instruction memory with a registered read port and a
// single-port load interface used to write the program before execution.
module memoria_instrucao
  import memoria_instrucao_pkg::*;
#(
  parameter int unsigned PROFUNDIDADE = PROFUNDIDADE_IMEM,
  parameter int unsigned LARGURA      = LARGURA_INSTR,
  parameter string       ARQUIVO_INIT = ""
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [31:0]        endereco,
  output logic [LARGURA-1:0] instrucaoOut,
  output logic               erro_endereco,
  input  logic               escrita,
  input  logic [31:0]        endereco_escrita,
  input  logic [LARGURA-1:0] dado_escrita
);

  localparam int unsigned IDX_W = (PROFUNDIDADE > 1) ? $clog2(PROFUNDIDADE) : 1;

  if ((PROFUNDIDADE & (PROFUNDIDADE - 1)) != 0) begin : g_profundidade_invalida
    $error("memoria_instrucao: PROFUNDIDADE must be a power of two");
  end

  // An address is in range only when every bit above the index field is clear;
  // there is deliberately no wrap-around onto the low bits.
  function automatic logic em_faixa(input logic [31:0] addr);
    return (addr >> IDX_W) == 32'd0;
  endfunction

  logic [LARGURA-1:0] mem [PROFUNDIDADE];

  logic [LARGURA-1:0] instr_d, instr_q;
  logic               erro_d,  erro_q;
  logic               wr_en;

  initial begin
    for (int i = 0; i < int'(PROFUNDIDADE); i++) mem[i] = '0;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves
    // a value unassigned and no latch can be inferred.
    instr_d = LARGURA'(INSTR_NOP);
    erro_d  = 1'b1;
    if (em_faixa(endereco)) begin
      instr_d = mem[endereco[IDX_W-1:0]];
      erro_d  = 1'b0;
    end
    wr_en = escrita && reset && em_faixa(endereco_escrita);
  end

  always_ff @(posedge clock or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs; this is also what makes a same-edge
    // read/write collision return the old word.
    if (!reset) begin
      instr_q <= LARGURA'(INSTR_NOP);
      erro_q  <= 1'b0;
    end else begin
      instr_q <= instr_d;
      erro_q  <= erro_d;
    end
  end

  // NOTE: the array has no reset on purpose -- the program must survive a
  // processor reset, and a resettable array cannot map onto block RAM.
  always @(posedge clock) begin
    if (wr_en) mem[endereco_escrita[IDX_W-1:0]] <= dado_escrita;
  end

  assign instrucaoOut  = instr_q;
  assign erro_endereco = erro_q;

endmodule : memoria_instrucao

// File: tb/tb_memoria_instrucao.sv
// Directed bench for memoria_instrucao: the driver queues expected fetch results,
// a monitor compares them one edge later.
module tb_memoria_instrucao;
  import memoria_instrucao_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] endereco;
  logic [31:0] instrucaoOut;
  logic        erro_endereco;
  logic        escrita;
  logic [31:0] endereco_escrita;
  logic [31:0] dado_escrita;

  memoria_instrucao dut (
    .clock            (clock),
    .reset            (reset),
    .endereco         (endereco),
    .instrucaoOut     (instrucaoOut),
    .erro_endereco    (erro_endereco),
    .escrita          (escrita),
    .endereco_escrita (endereco_escrita),
    .dado_escrita     (dado_escrita)
  );

  always #10 clock = ~clock;

  typedef struct {
    string       nome;
    logic [31:0] instr;
    logic        erro;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_falhas = 0;

  task automatic check(input string nome, input logic [31:0] obtido,
                       input logic [31:0] esperado);
    n_checks++;
    if (obtido !== esperado) begin
      n_falhas++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", nome, obtido, esperado, $time);
    end
  endtask

  task automatic push_exp(input string nome, input logic [31:0] instr, input logic erro);
    exp_t e;
    e.nome  = nome;
    e.instr = instr;
    e.erro  = erro;
    sb.push_back(e);
  endtask

  // Present a fetch address for the next rising edge and queue its result.
  task automatic fetch(input string nome, input logic [31:0] a,
                       input logic [31:0] instr, input logic erro);
    @(negedge clock);
    escrita  = 1'b0;
    endereco = a;
    push_exp(nome, instr, erro);
  endtask

  task automatic write_word(input logic [31:0] a, input logic [31:0] d);
    @(negedge clock);
    escrita          = 1'b1;
    endereco_escrita = a;
    dado_escrita     = d;
  endtask

  // Asynchronous reset pulse placed strictly between clock edges.
  task automatic pulso_reset(input string nome);
    @(posedge clock);
    #3 reset = 1'b0;
    #1;
    check({nome, "_instr"}, instrucaoOut, INSTR_NOP);
    check({nome, "_erro"}, {31'b0, erro_endereco}, 32'd0);
    #2 reset = 1'b1;
  endtask

  // Monitor: one edge after each queued fetch, compare what the DUT shows.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.nome, "_instr"}, instrucaoOut, e.instr);
        check({e.nome, "_erro"}, {31'b0, erro_endereco}, {31'b0, e.erro});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset            = 1'b0;
    endereco         = 32'd0;
    escrita          = 1'b0;
    endereco_escrita = 32'd0;
    dado_escrita     = 32'd0;

    #1;
    check("reset_t0_instr", instrucaoOut, INSTR_NOP);
    check("reset_t0_erro", {31'b0, erro_endereco}, 32'd0);

    // First edge after release loads the (still zero) word 0.
    @(negedge clock);
    reset = 1'b1;
    push_exp("pos_reset_mem0", 32'h0, 1'b0);

    write_word(32'd0,   32'h0000_0011);
    write_word(32'd1,   32'h0000_0022);
    write_word(32'd2,   32'h0000_0033);
    write_word(32'd3,   32'h0000_0044);
    write_word(32'd4,   32'h0000_0055);
    write_word(32'd255, 32'hDEAD_BEEF);
    write_word(32'd7,   32'hA5A5_A5A5);
    write_word(32'd256, 32'hFFFF_FFFF);
    write_word(32'h0100_0003, 32'hCAFE_CAFE);

    fetch("seq_0", 32'd0, 32'h0000_0011, 1'b0);
    fetch("seq_1", 32'd1, 32'h0000_0022, 1'b0);
    fetch("seq_2", 32'd2, 32'h0000_0033, 1'b0);
    fetch("seq_3", 32'd3, 32'h0000_0044, 1'b0);
    fetch("seq_4", 32'd4, 32'h0000_0055, 1'b0);

    fetch("estab_1", 32'd1, 32'h0000_0022, 1'b0);
    @(posedge clock);
    #2 endereco = 32'd2;
    #1 check("estab_meio_ciclo", instrucaoOut, 32'h0000_0022);
    fetch("estab_2", 32'd2, 32'h0000_0033, 1'b0);

    fetch("fora_256", 32'd256, INSTR_NOP, 1'b1);
    fetch("fora_ffff", 32'hFFFF_FFFF, INSTR_NOP, 1'b1);
    fetch("volta_255", 32'd255, 32'hDEAD_BEEF, 1'b0);

    @(negedge clock);
    endereco         = 32'd7;
    escrita          = 1'b1;
    endereco_escrita = 32'd7;
    dado_escrita     = 32'h5A5A_5A5A;
    push_exp("colisao_antigo", 32'hA5A5_A5A5, 1'b0);
    fetch("colisao_novo", 32'd7, 32'h5A5A_5A5A, 1'b0);

    fetch("fora_300", 32'd300, INSTR_NOP, 1'b1);
    pulso_reset("pulso_apos_erro");
    fetch("busca_33", 32'd2, 32'h0000_0033, 1'b0);
    pulso_reset("pulso_busca_33");
    fetch("preservado_33", 32'd2, 32'h0000_0033, 1'b0);

    // Reset held across an edge: output stays NOP and the write is dropped.
    @(negedge clock);
    reset            = 1'b0;
    endereco         = 32'd1;
    escrita          = 1'b1;
    endereco_escrita = 32'd4;
    dado_escrita     = 32'hBAD0_BAD0;
    @(posedge clock);
    #2 check("reset_segura_instr", instrucaoOut, INSTR_NOP);
    @(negedge clock);
    reset   = 1'b1;
    escrita = 1'b0;

    fetch("escrita_em_reset_ignorada", 32'd4, 32'h0000_0055, 1'b0);
    fetch("escrita_fora_sem_wrap_0", 32'd0, 32'h0000_0011, 1'b0);
    fetch("escrita_fora_sem_wrap_3", 32'd3, 32'h0000_0044, 1'b0);

    repeat (3) @(posedge clock);
    #2 check("scoreboard_vazio", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_falhas);
    $finish;
  end

endmodule : tb_memoria_instrucao
